mosaic_coord_scheduler: RTL and testbench
=========================================

# mosaic_coord_scheduler

Sequential coordinate scheduler for the background and OBJ mosaic effect. It tracks the raster position and holds a frame-shadowed copy of the MOSAIC register. For every pixel it produces mosaic-snapped coordinates (x − x mod (hsize+1), y − y mod (vsize+1)) using step counters instead of dividers. It sits between the raster timing generator and the BG/OBJ fetch circuits, which select snapped or raw coordinates with their per-layer mosaic enable bits.

## Interface
Parameters:
- H_VISIBLE, 240: visible pixels per line; column counter saturates at H_VISIBLE−1.
- V_TOTAL, 228: lines per frame; row counter saturates at V_TOTAL−1.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- frame_start  input  1  one-cycle pulse at line 0 of a new frame. Also counts as a line start.
- line_start  input  1  one-cycle pulse at the start of each scanline.
- pix_adv  input  1  advance the column by one pixel.
- mosaic_wr  input  1  write strobe for the MOSAIC register.
- mosaic_wdata  input  16  [3:0] BG H size, [7:4] BG V size, [11:8] OBJ H size, [15:12] OBJ V size.
- mosaic_active  output  16  active (shadowed) MOSAIC value.
- raw_x  output  8  current column.
- raw_y  output  8  current row.
- bg_x  output  8  BG-snapped column.
- bg_y  output  8  BG-snapped row.
- obj_x  output  8  OBJ-snapped column.
- obj_y  output  8  OBJ-snapped row.

## Operation
- Two-level register:
  - mosaic_wr loads the pending register on the same edge. The last write in a frame wins.
  - The pending value copies into mosaic_active on frame_start.
  - If mosaic_wr and frame_start occur in the same cycle, mosaic_active takes the new mosaic_wdata directly.
- Axis counter, one each for BG-H, BG-V, OBJ-H and OBJ-V. Each holds step (4 bits) and base (8 bits):
  - Restart: step=0, base=0.
  - Advance, when step==size: step=0 and base=new coordinate.
  - Advance, otherwise: step=step+1 and base is unchanged.
  - Result: base always equals coord − (coord mod (size+1)). size=0 gives pass-through.
- Horizontal counters:
  - Restart on line_start or frame_start.
  - Advance on pix_adv while raw_x < H_VISIBLE−1.
  - At saturation, pix_adv is ignored: raw_x, base and step all hold.
- Vertical counters:
  - Restart on frame_start.
  - Advance on line_start while raw_y < V_TOTAL−1. At saturation raw_y holds.
- Priority for simultaneous events: frame_start > line_start > pix_adv. pix_adv arriving in the same cycle as either start pulse is dropped.
- Size source: counters always use mosaic_active sizes, never the pending register. A frame_start that also reloads sizes restarts counters with the new sizes already applied.
- Arithmetic is unsigned. The step compare is 4-bit and the coordinate is 8-bit; no wrap is possible within saturation limits.

## Timing
- All outputs are registered.
- An event sampled at edge N is visible on outputs after edge N; the consumer sees it in cycle N+1. Latency is 1 cycle with no bubbles, and pix_adv may be asserted every cycle.
- Reset: every output is 0, the pending register is 0, and all steps are 0.
- Reset mid-line or mid-frame returns everything to reset state asynchronously. Counting resumes only from the next frame_start or line_start pulse.
- A mosaic_wr mid-line or mid-frame never alters bg_*/obj_* until the next frame_start.

## Structure
- Package gba_mosaic_pkg:
  - Typedef mosaic_reg_t, a packed struct {obj_v, obj_h, bg_v, bg_h} of 4 bits each.
  - Constants MOSAIC_H_VISIBLE=240 and MOSAIC_V_TOTAL=228.
  - Typedef coord_t as logic [7:0].
- Sub-module mosaic_axis_counter:
  - Inputs: clk, rst_n, restart, advance, size[3:0], coord_next[7:0].
  - Output: base[7:0].
  - Instantiated four times. The top level owns raw_x/raw_y, saturation, priority and the register shadowing.

## Test plan
- Reset release: all outputs are 0. With BG H=3, 8 consecutive pix_adv give bg_x 0,0,0,0,4,4,4,4 and raw_x 0..7.
- BG V=2 and OBJ V=0 over 7 line_start pulses: bg_y 0,0,0,3,3,3,6. obj_y follows raw_y 0..6.
- A mosaic_wr of 0x00F0 mid-frame leaves bg_y unchanged until frame_start. After frame_start, V size=15 is applied and mosaic_active=0x00F0.
- pix_adv and line_start in the same cycle: raw_x=0 and bg_x=0, with the pixel dropped. frame_start and line_start together: raw_y=0.
- 300 pix_adv with H=0: raw_x saturates at 239 and bg_x=239, stable thereafter.
- rst_n asserted mid-line at raw_x=100: outputs go to 0 asynchronously and stay 0 until the next pulse, then count normally.

Source files
------------

// File: rtl/gba_mosaic_pkg.sv
// Shared types and raster limits for the mosaic coordinate scheduler.
package gba_mosaic_pkg;

   localparam int MOSAIC_H_VISIBLE = 240;
   localparam int MOSAIC_V_TOTAL   = 228;

   typedef logic [7:0] coord_t;

   typedef struct packed {
      logic [3:0] obj_v;
      logic [3:0] obj_h;
      logic [3:0] bg_v;
      logic [3:0] bg_h;
   } mosaic_reg_t;

endpackage

// File: rtl/mosaic_axis_counter.sv
// One mosaic axis: base tracks coord - (coord mod (size+1)) with a small step counter.
module mosaic_axis_counter
   import gba_mosaic_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       restart,
   input  logic       advance,
   input  logic [3:0] size,
   input  coord_t     coord_next,
   output coord_t     base
);

   logic [3:0] step;

   // A full block of size+1 coordinates has elapsed when step reaches size;
   // the coordinate arriving then starts the next block.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         step <= 4'd0;
         base <= 8'd0;
      end else if (restart) begin
         step <= 4'd0;
         base <= 8'd0;
      end else if (advance) begin
         if (step == size) begin
            step <= 4'd0;
            base <= coord_next;
         end else begin
            step <= step + 4'd1;
         end
      end
   end

endmodule

// File: rtl/mosaic_coord_scheduler.sv
// Raster position tracker with frame-shadowed MOSAIC register and snapped BG/OBJ coordinates.
module mosaic_coord_scheduler
   import gba_mosaic_pkg::*;
#(
   parameter int H_VISIBLE = MOSAIC_H_VISIBLE,
   parameter int V_TOTAL   = MOSAIC_V_TOTAL
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        frame_start,
   input  logic        line_start,
   input  logic        pix_adv,
   input  logic        mosaic_wr,
   input  logic [15:0] mosaic_wdata,
   output logic [15:0] mosaic_active,
   output logic [7:0]  raw_x,
   output logic [7:0]  raw_y,
   output logic [7:0]  bg_x,
   output logic [7:0]  bg_y,
   output logic [7:0]  obj_x,
   output logic [7:0]  obj_y
);

   localparam coord_t X_MAX = coord_t'(H_VISIBLE - 1);
   localparam coord_t Y_MAX = coord_t'(V_TOTAL - 1);

   mosaic_reg_t pending;
   mosaic_reg_t active;
   logic        running;
   coord_t      x_next;
   coord_t      y_next;
   logic        h_restart;
   logic        h_adv;
   logic        v_restart;
   logic        v_adv;

   assign x_next    = raw_x + 8'd1;
   assign y_next    = raw_y + 8'd1;
   assign h_restart = frame_start | line_start;
   assign h_adv     = pix_adv & running & ~h_restart & (raw_x < X_MAX);
   assign v_restart = frame_start;
   assign v_adv     = line_start & ~frame_start & running & (raw_y < Y_MAX);

   assign mosaic_active = active;

   // The pending copy absorbs writes; a write coinciding with frame_start goes straight through.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pending <= '0;
         active  <= '0;
      end else begin
         if (mosaic_wr) begin
            pending <= mosaic_wdata;
         end
         if (frame_start) begin
            active <= mosaic_wr ? mosaic_reg_t'(mosaic_wdata) : pending;
         end
      end
   end

   // After reset nothing counts until a start pulse re-synchronises us to the raster.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         running <= 1'b0;
         raw_x   <= 8'd0;
         raw_y   <= 8'd0;
      end else begin
         if (h_restart) begin
            running <= 1'b1;
            raw_x   <= 8'd0;
         end else if (h_adv) begin
            raw_x   <= x_next;
         end
         if (v_restart) begin
            raw_y <= 8'd0;
         end else if (v_adv) begin
            raw_y <= y_next;
         end
      end
   end

   mosaic_axis_counter u_bg_h (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart    (h_restart),
      .advance    (h_adv),
      .size       (active.bg_h),
      .coord_next (x_next),
      .base       (bg_x)
   );

   mosaic_axis_counter u_bg_v (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart    (v_restart),
      .advance    (v_adv),
      .size       (active.bg_v),
      .coord_next (y_next),
      .base       (bg_y)
   );

   mosaic_axis_counter u_obj_h (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart    (h_restart),
      .advance    (h_adv),
      .size       (active.obj_h),
      .coord_next (x_next),
      .base       (obj_x)
   );

   mosaic_axis_counter u_obj_v (
      .clk        (clk),
      .rst_n      (rst_n),
      .restart    (v_restart),
      .advance    (v_adv),
      .size       (active.obj_v),
      .coord_next (y_next),
      .base       (obj_y)
   );

endmodule

// File: tb/tb_mosaic_coord_scheduler.sv
// Scenario-driven bench for mosaic_coord_scheduler with a modulo-arithmetic reference model.
module tb_mosaic_coord_scheduler;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        frame_start = 1'b0;
   logic        line_start = 1'b0;
   logic        pix_adv = 1'b0;
   logic        mosaic_wr = 1'b0;
   logic [15:0] mosaic_wdata = 16'h0000;
   logic [15:0] mosaic_active;
   logic [7:0]  raw_x, raw_y, bg_x, bg_y, obj_x, obj_y;

   int          checks = 0;
   int          errors = 0;

   int          m_x, m_y;
   logic [15:0] m_active, m_pending;
   bit          m_run;

   mosaic_coord_scheduler dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .frame_start   (frame_start),
      .line_start    (line_start),
      .pix_adv       (pix_adv),
      .mosaic_wr     (mosaic_wr),
      .mosaic_wdata  (mosaic_wdata),
      .mosaic_active (mosaic_active),
      .raw_x         (raw_x),
      .raw_y         (raw_y),
      .bg_x          (bg_x),
      .bg_y          (bg_y),
      .obj_x         (obj_x),
      .obj_y         (obj_y)
   );

   always #5 clk = ~clk;

   function automatic logic [7:0] snap(input int c, input logic [3:0] s);
      int d;
      d = int'(s) + 1;
      return 8'(c - (c % d));
   endfunction

   task automatic model_reset();
      m_x = 0;
      m_y = 0;
      m_active = 16'h0000;
      m_pending = 16'h0000;
      m_run = 1'b0;
   endtask

   // Drive one cycle of inputs, let the edge happen, then advance the reference model.
   task automatic cycle(input bit fs, input bit ls, input bit pa, input bit wr, input logic [15:0] wd);
      frame_start = fs;
      line_start = ls;
      pix_adv = pa;
      mosaic_wr = wr;
      mosaic_wdata = wd;
      @(posedge clk);
      #1;
      if (wr) m_pending = wd;
      if (fs) m_active = m_pending;
      if (fs) begin
         m_x = 0;
         m_y = 0;
         m_run = 1'b1;
      end else if (ls) begin
         m_x = 0;
         if (m_run && m_y < 227) m_y++;
         m_run = 1'b1;
      end else if (pa && m_run && m_x < 239) begin
         m_x++;
      end
      frame_start = 1'b0;
      line_start = 1'b0;
      pix_adv = 1'b0;
      mosaic_wr = 1'b0;
   endtask

   task automatic test_reset();
      model_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
      #1;
      checks++; if (mosaic_active !== 16'h0000) begin errors++; $display("[TB] FAIL reset_active: got %h expected 0000", mosaic_active); end
      checks++; if (raw_x !== 8'd0) begin errors++; $display("[TB] FAIL reset_raw_x: got %0d expected 0", raw_x); end
      checks++; if (raw_y !== 8'd0) begin errors++; $display("[TB] FAIL reset_raw_y: got %0d expected 0", raw_y); end
      checks++; if (bg_x !== 8'd0) begin errors++; $display("[TB] FAIL reset_bg_x: got %0d expected 0", bg_x); end
      checks++; if (bg_y !== 8'd0) begin errors++; $display("[TB] FAIL reset_bg_y: got %0d expected 0", bg_y); end
      checks++; if (obj_x !== 8'd0) begin errors++; $display("[TB] FAIL reset_obj_x: got %0d expected 0", obj_x); end
      checks++; if (obj_y !== 8'd0) begin errors++; $display("[TB] FAIL reset_obj_y: got %0d expected 0", obj_y); end
   endtask

   task automatic test_bg_h();
      cycle(1, 0, 0, 1, 16'h0003);
      checks++; if (mosaic_active !== 16'h0003) begin errors++; $display("[TB] FAIL bg_h_active: got %h expected 0003", mosaic_active); end
      for (int i = 0; i < 8; i++) begin
         cycle(0, 0, 1, 0, 16'h0000);
         checks++; if (raw_x !== 8'(m_x)) begin errors++; $display("[TB] FAIL bg_h_raw_x[%0d]: got %0d expected %0d", i, raw_x, m_x); end
         checks++; if (bg_x !== snap(m_x, m_active[3:0])) begin errors++; $display("[TB] FAIL bg_h_bg_x[%0d]: got %0d expected %0d", i, bg_x, snap(m_x, m_active[3:0])); end
      end
      checks++; if (bg_x !== 8'd8) begin errors++; $display("[TB] FAIL bg_h_final: got %0d expected 8", bg_x); end
   endtask

   task automatic test_bg_v();
      cycle(1, 0, 0, 1, 16'h0020);
      for (int i = 0; i < 7; i++) begin
         cycle(0, 1, 0, 0, 16'h0000);
         cycle(0, 0, 1, 0, 16'h0000);
         checks++; if (raw_y !== 8'(m_y)) begin errors++; $display("[TB] FAIL bg_v_raw_y[%0d]: got %0d expected %0d", i, raw_y, m_y); end
         checks++; if (bg_y !== snap(m_y, m_active[7:4])) begin errors++; $display("[TB] FAIL bg_v_bg_y[%0d]: got %0d expected %0d", i, bg_y, snap(m_y, m_active[7:4])); end
         checks++; if (obj_y !== 8'(m_y)) begin errors++; $display("[TB] FAIL bg_v_obj_y[%0d]: got %0d expected %0d", i, obj_y, m_y); end
      end
      checks++; if (bg_y !== 8'd6) begin errors++; $display("[TB] FAIL bg_v_final: got %0d expected 6", bg_y); end
   endtask

   task automatic test_shadow();
      cycle(0, 0, 0, 1, 16'h00F0);
      checks++; if (mosaic_active !== 16'h0020) begin errors++; $display("[TB] FAIL shadow_hold: got %h expected 0020", mosaic_active); end
      for (int i = 0; i < 3; i++) begin
         cycle(0, 1, 0, 0, 16'h0000);
         checks++; if (bg_y !== snap(m_y, 4'd2)) begin errors++; $display("[TB] FAIL shadow_old_bg_y[%0d]: got %0d expected %0d", i, bg_y, snap(m_y, 4'd2)); end
      end
      cycle(1, 0, 0, 0, 16'h0000);
      checks++; if (mosaic_active !== 16'h00F0) begin errors++; $display("[TB] FAIL shadow_load: got %h expected 00F0", mosaic_active); end
      for (int i = 0; i < 18; i++) begin
         cycle(0, 1, 0, 0, 16'h0000);
         checks++; if (bg_y !== snap(m_y, 4'd15)) begin errors++; $display("[TB] FAIL shadow_new_bg_y[%0d]: got %0d expected %0d", i, bg_y, snap(m_y, 4'd15)); end
      end
   endtask

   task automatic test_collide();
      cycle(1, 0, 0, 1, 16'h0000);
      repeat (5) cycle(0, 0, 1, 0, 16'h0000);
      cycle(0, 1, 1, 0, 16'h0000);
      checks++; if (raw_x !== 8'd0) begin errors++; $display("[TB] FAIL collide_raw_x: got %0d expected 0", raw_x); end
      checks++; if (bg_x !== 8'd0) begin errors++; $display("[TB] FAIL collide_bg_x: got %0d expected 0", bg_x); end
      repeat (4) cycle(0, 1, 0, 0, 16'h0000);
      checks++; if (raw_y !== 8'd5) begin errors++; $display("[TB] FAIL collide_lines: got %0d expected 5", raw_y); end
      cycle(1, 1, 1, 0, 16'h0000);
      checks++; if (raw_y !== 8'd0) begin errors++; $display("[TB] FAIL collide_raw_y: got %0d expected 0", raw_y); end
      checks++; if (raw_x !== 8'd0) begin errors++; $display("[TB] FAIL collide_fs_raw_x: got %0d expected 0", raw_x); end
   endtask

   task automatic test_saturate();
      cycle(1, 0, 0, 1, 16'h0000);
      repeat (300) cycle(0, 0, 1, 0, 16'h0000);
      checks++; if (raw_x !== 8'd239) begin errors++; $display("[TB] FAIL sat_raw_x: got %0d expected 239", raw_x); end
      checks++; if (bg_x !== 8'd239) begin errors++; $display("[TB] FAIL sat_bg_x: got %0d expected 239", bg_x); end
      for (int i = 0; i < 4; i++) begin
         cycle(0, 0, 1, 0, 16'h0000);
         checks++; if (raw_x !== 8'(m_x) || bg_x !== 8'(m_x)) begin errors++; $display("[TB] FAIL sat_hold[%0d]: got %0d/%0d expected %0d", i, raw_x, bg_x, m_x); end
      end
   endtask

   task automatic test_reset_midline();
      cycle(1, 0, 0, 1, 16'h1111);
      repeat (100) cycle(0, 0, 1, 0, 16'h0000);
      checks++; if (raw_x !== 8'd100) begin errors++; $display("[TB] FAIL midline_pre: got %0d expected 100", raw_x); end
      #3 rst_n = 1'b0;
      #1;
      model_reset();
      checks++; if (raw_x !== 8'd0 || bg_x !== 8'd0 || obj_x !== 8'd0) begin errors++; $display("[TB] FAIL midline_async: got %0d/%0d/%0d expected 0", raw_x, bg_x, obj_x); end
      checks++; if (mosaic_active !== 16'h0000) begin errors++; $display("[TB] FAIL midline_active: got %h expected 0000", mosaic_active); end
      @(posedge clk);
      #2 rst_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         cycle(0, 0, 1, 0, 16'h0000);
         checks++; if (raw_x !== 8'd0 || bg_x !== 8'd0) begin errors++; $display("[TB] FAIL midline_idle[%0d]: got %0d/%0d expected 0", i, raw_x, bg_x); end
      end
      cycle(1, 0, 0, 0, 16'h0000);
      for (int i = 0; i < 10; i++) begin
         cycle(0, 0, 1, 0, 16'h0000);
         checks++; if (raw_x !== 8'(m_x)) begin errors++; $display("[TB] FAIL midline_resume[%0d]: got %0d expected %0d", i, raw_x, m_x); end
      end
   endtask

   task automatic test_random();
      bit fs, ls, pa, wr;
      logic [15:0] wd;
      cycle(1, 0, 0, 1, 16'($urandom));
      for (int i = 0; i < 800; i++) begin
         fs = ($urandom % 150) == 0;
         ls = ($urandom % 25) == 0;
         pa = ($urandom % 4) != 0;
         wr = ($urandom % 40) == 0;
         wd = 16'($urandom);
         cycle(fs, ls, pa, wr, wd);
         checks++;
         if (mosaic_active !== m_active || raw_x !== 8'(m_x) || raw_y !== 8'(m_y)
             || bg_x !== snap(m_x, m_active[3:0]) || bg_y !== snap(m_y, m_active[7:4])
             || obj_x !== snap(m_x, m_active[11:8]) || obj_y !== snap(m_y, m_active[15:12])) begin
            errors++;
            $display("[TB] FAIL random[%0d]: got act=%h x=%0d y=%0d bg=%0d,%0d obj=%0d,%0d expected act=%h x=%0d y=%0d bg=%0d,%0d obj=%0d,%0d",
                     i, mosaic_active, raw_x, raw_y, bg_x, bg_y, obj_x, obj_y,
                     m_active, m_x, m_y, snap(m_x, m_active[3:0]), snap(m_y, m_active[7:4]),
                     snap(m_x, m_active[11:8]), snap(m_y, m_active[15:12]));
         end
      end
   endtask

   initial begin
      test_reset();
      test_bg_h();
      test_bg_v();
      test_shadow();
      test_collide();
      test_saturate();
      test_reset_midline();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
